i2c_target_fifo: RTL and testbench
==================================

# i2c_target_fifo

Parametrised next-generation I2C target with full write and read support, address masking, byte-stream valid/ready interfaces on both directions, and optional clock stretching. Sits between the open-drain pad cells (scl/sda split into _i/_o) and an on-chip controller or register bank. It is the successor to the fixed-address, write-only target block.

## Interface
- SLAVE_ADDRESS, 7'h21, 7-bit target address
- ADDR_MASK, 7'h7F, address bits compared; 0 bits are don't-care
- GEN_CALL, 1'b0, 1 = also ACK address 7'h00 (write only)
- clk  input  1  system clock, must be ≥ 16× SCL frequency
- rst  input  1  reset, asynchronous, active-high
- scl_i  input  1  SCL from pad, asynchronous
- sda_i  input  1  SDA from pad, asynchronous
- scl_o  output  1  SCL drive, 0 = pull low
- sda_o  output  1  SDA drive, 0 = pull low
- rx_data  output  8  received write byte
- rx_first  output  1  rx_data is the first byte after the address
- rx_valid  output  1  rx_data valid
- rx_ready  input  1  consumer accepts rx_data
- tx_data  input  8  byte to send on read
- tx_valid  input  1  tx_data valid
- tx_ready  output  1  one-cycle pulse: tx_data taken
- matched_addr  output  7  address of the current transfer
- busy  output  1  addressed transaction in progress
- evt_stop  output  1  one-cycle pulse on STOP after an addressed transfer
- evt_err  output  1  one-cycle pulse: rx overflow or tx underflow

## Operation
- Inputs pass a 2-FF synchroniser (reset value 1), then a delay stage; scl_rise/scl_fall/START/STOP are derived from synchronised values. START = SDA fall with SCL high; STOP = SDA rise with SCL high.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- IDLE→ADDR on START. ADDR shifts 8 bits MSB-first on scl_rise (7 address bits + R/W).
- Match: (addr & ADDR_MASK) == (SLAVE_ADDRESS & ADDR_MASK), or addr==0 with W and GEN_CALL. Match → ADDR_ACK (sda_o=0 from next scl_fall to the following scl_fall), matched_addr latched, busy=1. No match → WAIT_STOP, SDA released.
- ADDR_ACK → WR_DATA (W) or RD_DATA (R) on the scl_fall that ends the ACK bit.
- Write: 8 bits shifted on scl_rise. On the 8th scl_rise, if the holding register is free (rx_valid=0), the byte is loaded, rx_valid=1 next cycle, and ACK is driven in WR_ACK. rx_valid stays until rx_valid&rx_ready. If the holding register is occupied, see Configuration. WR_ACK → WR_DATA on scl_fall.
- Read: on the scl_fall entering RD_DATA, if tx_valid=1, tx_data loads into the shifter and tx_ready pulses. Bits are driven MSB-first, each changing 1 cycle after the detected scl_fall. After the 8th bit, SDA is released in RD_ACK and the master bit is sampled on scl_rise. ACK (0) → RD_DATA. NACK (1) → WAIT_STOP.
- Repeated START in any state → ADDR; the bit counter is cleared and rx_first rearms. STOP in any state → IDLE, SDA/SCL released, busy=0. evt_stop pulses if busy was 1.
- rx_first=1 for the first byte after each address phase.

## Timing
- Reset values: scl_o=1, sda_o=1, rx_data=0, rx_first=0, rx_valid=0, tx_ready=0, matched_addr=0, busy=0, evt_stop=0, evt_err=0; state IDLE.
- Bus-to-internal latency: 3 clk (2 sync + 1 edge stage). sda_o updates 1 clk after detected scl_fall.
- rx_valid rises 1 clk after the 8th detected scl_rise. tx_ready pulses in the same cycle the shifter loads.
- rx_valid&rx_ready with a simultaneous new byte load: load wins, rx_valid stays 1.
- Reset mid-transfer releases both lines immediately (asynchronous) and discards buffered bytes.

## Configuration
- I2C_TARGET_CLK_STRETCH_EN defined: rx register occupied at the 8th bit, or tx_valid=0 at RD_DATA entry → scl_o=0 from that scl_fall until a free register / tx_valid is available, then byte handled normally. No data loss and no evt_err. A STOP or START while stretching aborts the stretch.
- Not defined: scl_o constant 1. Rx overflow → byte dropped, NACK, evt_err pulse. Tx underflow → 8'hFF sent, evt_err pulse.

## Structure
- Package i2c_pkg: state enum i2c_tgt_state_t, BIT_COUNT_MAX=4'd7, GEN_CALL_ADDR=7'h00.
- Sub-module i2c_bus_sync: synchronisers plus scl_rise/scl_fall/start/stop pulse generation.

## Test plan
- Write addr 0x21 then bytes 0xA5,0x3C with rx_ready=1 → both ACKed, rx_data 0xA5 (rx_first=1) then 0x3C (rx_first=0), evt_stop after STOP.
- Read addr 0x21, tx_data 0x96 then 0x0F, master ACK then NACK → SDA bits 10010110, 00001111; two tx_ready pulses; WAIT_STOP.
- Addr 0x22 with ADDR_MASK=7'h7C → ACKed, matched_addr=0x22. Addr 0x45 → no ACK, busy stays 0.
- rx_ready=0, write two bytes. No macro: second byte NACKed, evt_err pulse. Macro defined: SCL held low until rx_ready=1, then ACK.
- Read with tx_valid=0. No macro: 0xFF sent, evt_err pulse. Macro defined: SCL low until tx_valid.
- Repeated START mid-write, then read → state ADDR, rx_first rearms; rst pulse mid-byte → all outputs at reset values.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding and shared constants for the I2C target.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } i2c_tgt_state_t;

  localparam logic [3:0] BIT_COUNT_MAX = 4'd7;
  localparam logic [3:0] RD_BITS       = 4'd8;
  localparam logic [6:0] GEN_CALL_ADDR = 7'h00;

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: 2-FF synchronisers for SCL/SDA plus registered edge and
// START/STOP pulses. Pulses appear 3 clk after the pad transition and are
// aligned with the delayed SDA level on the sda output.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_d;
  logic       sda_d;

  assign sda = sda_d;

  // Synchronise the pads (idle-high reset) and derive one-cycle bus events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_ff   <= 2'b11;
      sda_ff   <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start    <= 1'b0;
      stop     <= 1'b0;
    end else begin
      scl_ff   <= {scl_ff[0], scl_i};
      sda_ff   <= {sda_ff[0], sda_i};
      scl_d    <= scl_ff[1];
      sda_d    <= sda_ff[1];
      scl_rise <= scl_ff[1] & ~scl_d;
      scl_fall <= ~scl_ff[1] & scl_d;
      start    <= scl_ff[1] & scl_d & ~sda_ff[1] & sda_d;
      stop     <= scl_ff[1] & scl_d & sda_ff[1] & ~sda_d;
    end
  end

endmodule

// File: rtl/i2c_target_fifo.sv
// i2c_target_fifo: I2C target with masked address match, write/read byte
// streams and optional clock stretching (define I2C_TARGET_CLK_STRETCH_EN).
module i2c_target_fifo
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h21,
  parameter logic [6:0] ADDR_MASK     = 7'h7F,
  parameter logic       GEN_CALL      = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic [7:0] rx_data,
  output logic       rx_first,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [6:0] matched_addr,
  output logic       busy,
  output logic       evt_stop,
  output logic       evt_err
);

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic bus_start;
  logic bus_stop;

  i2c_bus_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda      (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (bus_start),
    .stop     (bus_stop)
  );

  i2c_tgt_state_t state;
  logic [7:0]     sh;
  logic [3:0]     bit_cnt;
  logic           rw;
  logic           ack_on;
  logic           wr_ack;
  logic           first_pending;
`ifdef I2C_TARGET_CLK_STRETCH_EN
  logic           stretch_wr;
  logic           stretch_rd;
`endif

  logic [7:0] byte_in;
  logic       addr_hit;
  logic       rx_free;
  logic       rd_enter;

  // Byte being completed, address match and read-byte fetch conditions.
  assign byte_in  = {sh[6:0], sda_s};
  assign addr_hit = ((sh[6:0] & ADDR_MASK) == (SLAVE_ADDRESS & ADDR_MASK)) ||
                    (GEN_CALL && (sh[6:0] == GEN_CALL_ADDR) && !sda_s);
  assign rx_free  = !rx_valid || rx_ready;
  assign rd_enter = scl_fall && ack_on &&
                    ((state == ADDR_ACK && rw) || state == RD_ACK);

  // Protocol FSM; bus START/STOP handling is last so it overrides any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      scl_o         <= 1'b1;
      sda_o         <= 1'b1;
      rx_data       <= 8'h00;
      rx_first      <= 1'b0;
      rx_valid      <= 1'b0;
      tx_ready      <= 1'b0;
      matched_addr  <= 7'h00;
      busy          <= 1'b0;
      evt_stop      <= 1'b0;
      evt_err       <= 1'b0;
      sh            <= 8'h00;
      bit_cnt       <= 4'd0;
      rw            <= 1'b0;
      ack_on        <= 1'b0;
      wr_ack        <= 1'b0;
      first_pending <= 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
      stretch_wr    <= 1'b0;
      stretch_rd    <= 1'b0;
`endif
    end else begin
      tx_ready <= 1'b0;
      evt_stop <= 1'b0;
      evt_err  <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        ADDR: begin
          if (scl_rise) begin
            sh      <= byte_in;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == BIT_COUNT_MAX) begin
              ack_on <= 1'b0;
              rw     <= sda_s;
              if (addr_hit) begin
                state         <= ADDR_ACK;
                matched_addr  <= sh[6:0];
                busy          <= 1'b1;
                first_pending <= 1'b1;
              end else begin
                state <= WAIT_STOP;
                busy  <= 1'b0;
              end
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_on) begin
              sda_o  <= 1'b0;
              ack_on <= 1'b1;
            end else begin
              sda_o   <= 1'b1;
              bit_cnt <= 4'd0;
              state   <= rw ? RD_DATA : WR_DATA;
            end
          end
        end

        WR_DATA: begin
          if (scl_rise) begin
            sh      <= byte_in;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == BIT_COUNT_MAX) begin
              state  <= WR_ACK;
              ack_on <= 1'b0;
              if (rx_free) begin
                rx_data       <= byte_in;
                rx_valid      <= 1'b1;
                rx_first      <= first_pending;
                first_pending <= 1'b0;
                wr_ack        <= 1'b1;
              end else begin
`ifdef I2C_TARGET_CLK_STRETCH_EN
                wr_ack     <= 1'b1;
                stretch_wr <= 1'b1;
`else
                wr_ack     <= 1'b0;
                evt_err    <= 1'b1;
`endif
              end
            end
          end
        end

        WR_ACK: begin
`ifdef I2C_TARGET_CLK_STRETCH_EN
          // Deferred byte lands as soon as the holding register frees up.
          if (stretch_wr && rx_free) begin
            rx_data       <= sh;
            rx_valid      <= 1'b1;
            rx_first      <= first_pending;
            first_pending <= 1'b0;
            stretch_wr    <= 1'b0;
            scl_o         <= 1'b1;
          end
`endif
          if (scl_fall) begin
            if (!ack_on) begin
              sda_o  <= !wr_ack;
              ack_on <= 1'b1;
`ifdef I2C_TARGET_CLK_STRETCH_EN
              if (stretch_wr && !rx_free) scl_o <= 1'b0;
`endif
            end else begin
              sda_o   <= 1'b1;
              bit_cnt <= 4'd0;
              state   <= WR_DATA;
            end
          end
        end

        RD_DATA: begin
`ifdef I2C_TARGET_CLK_STRETCH_EN
          if (stretch_rd && tx_valid) begin
            sda_o      <= tx_data[7];
            sh         <= {tx_data[6:0], 1'b0};
            bit_cnt    <= 4'd1;
            tx_ready   <= 1'b1;
            scl_o      <= 1'b1;
            stretch_rd <= 1'b0;
          end
`endif
          if (scl_fall) begin
            if (bit_cnt == RD_BITS) begin
              sda_o  <= 1'b1;
              ack_on <= 1'b0;
              state  <= RD_ACK;
            end else begin
              sda_o   <= sh[7];
              sh      <= {sh[6:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end

        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) state <= WAIT_STOP;
            else       ack_on <= 1'b1;
          end
        end

        default: ;
      endcase

      // Fetch the next read byte on the falling edge that opens it.
      if (rd_enter) begin
        state <= RD_DATA;
        if (tx_valid) begin
          sda_o    <= tx_data[7];
          sh       <= {tx_data[6:0], 1'b0};
          bit_cnt  <= 4'd1;
          tx_ready <= 1'b1;
        end else begin
`ifdef I2C_TARGET_CLK_STRETCH_EN
          sda_o      <= 1'b1;
          scl_o      <= 1'b0;
          stretch_rd <= 1'b1;
`else
          sda_o   <= 1'b1;
          sh      <= 8'hFE;
          bit_cnt <= 4'd1;
          evt_err <= 1'b1;
`endif
        end
      end

      if (bus_stop) begin
        state    <= IDLE;
        sda_o    <= 1'b1;
        scl_o    <= 1'b1;
        busy     <= 1'b0;
        evt_stop <= busy;
`ifdef I2C_TARGET_CLK_STRETCH_EN
        stretch_wr <= 1'b0;
        stretch_rd <= 1'b0;
`endif
      end else if (bus_start) begin
        state         <= ADDR;
        bit_cnt       <= 4'd0;
        sda_o         <= 1'b1;
        scl_o         <= 1'b1;
        first_pending <= 1'b1;
`ifdef I2C_TARGET_CLK_STRETCH_EN
        stretch_wr <= 1'b0;
        stretch_rd <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_fifo.sv
// tb_i2c_target_fifo: directed I2C master driving i2c_target_fifo through
// write, read, masking, overflow/underflow, repeated START and reset.
// Expectations follow I2C_TARGET_CLK_STRETCH_EN when it is defined.
module tb_i2c_target_fifo;

  localparam int unsigned Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m, sda_m;
  logic       scl_i, sda_i, scl_o, sda_o;
  logic [7:0] rx_data, tx_data;
  logic       rx_first, rx_valid, rx_ready;
  logic       tx_valid, tx_ready;
  logic [6:0] matched_addr;
  logic       busy, evt_stop, evt_err;

  int n_checks = 0;
  int n_errors = 0;
  int tx_pulses = 0;
  int err_pulses = 0;
  int stop_pulses = 0;
  logic [8:0] rxq[$];

  always #5 clk = ~clk;

  assign scl_i = scl_m & scl_o;
  assign sda_i = sda_m & sda_o;

  i2c_target_fifo #(
    .SLAVE_ADDRESS (7'h21),
    .ADDR_MASK     (7'h7C),
    .GEN_CALL      (1'b0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .scl_i        (scl_i),
    .sda_i        (sda_i),
    .scl_o        (scl_o),
    .sda_o        (sda_o),
    .rx_data      (rx_data),
    .rx_first     (rx_first),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .matched_addr (matched_addr),
    .busy         (busy),
    .evt_stop     (evt_stop),
    .evt_err      (evt_err)
  );

  // Record accepted bytes and count pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) rxq.push_back({rx_first, rx_data});
      if (tx_ready) tx_pulses++;
      if (evt_err) err_pulses++;
      if (evt_stop) stop_pulses++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reset_vec();
    return 32'({scl_o, sda_o, rx_valid, rx_first, tx_ready, busy, evt_stop, evt_err,
                rx_data, 1'b0, matched_addr});
  endfunction

  function automatic logic [31:0] get_rx(input int i);
    if (i < rxq.size()) return 32'(rxq[i]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_high();
    int t = 0;
    scl_m = 1'b1;
    while (scl_i !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("scl_release", 32'(scl_i), 32'd1);
    tick(Q);
  endtask

  task automatic write_bit(input logic v);
    sda_m = v;
    tick(Q);
    scl_high();
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic read_bit(output logic v);
    sda_m = 1'b1;
    tick(Q);
    scl_high();
    v = sda_i;
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(ack);
  endtask

  task automatic read8(output logic [7:0] b);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      read_bit(v);
      b[i] = v;
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    tick(Q);
    scl_high();
    sda_m = 1'b0;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    tick(Q);
    scl_high();
    sda_m = 1'b1;
    tick(Q);
  endtask

  task automatic wait_stretch(input string tag);
    int t = 0;
    while (scl_o !== 1'b0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(scl_o), 32'd0);
    tick(100);
    chk({tag, "_held"}, 32'(scl_o), 32'd0);
  endtask

  logic       ack;
  logic [7:0] b;
  int         base_tx, base_err, base_stop;
  logic [7:0] pat;

  initial begin
    scl_m = 1'b1; sda_m = 1'b1;
    rx_ready = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    tick(3);
    chk("reset_state", reset_vec(), 32'h00C0_0000);
    rst = 1'b0;
    tick(5);

    // Write 0x21: bytes 0xA5, 0x3C with consumer ready.
    rxq.delete(); base_stop = stop_pulses;
    i2c_start();
    write_byte(8'h42, ack); chk("w_addr_ack", 32'(ack), 32'd0);
    chk("w_busy", 32'(busy), 32'd1);
    chk("w_matched", 32'(matched_addr), 32'h21);
    write_byte(8'hA5, ack); chk("w_ack0", 32'(ack), 32'd0);
    write_byte(8'h3C, ack); chk("w_ack1", 32'(ack), 32'd0);
    i2c_stop(); tick(8);
    chk("w_rx_count", 32'(rxq.size()), 32'd2);
    chk("w_rx0", get_rx(0), 32'h1A5);
    chk("w_rx1", get_rx(1), 32'h03C);
    chk("w_evt_stop", 32'(stop_pulses - base_stop), 32'd1);
    chk("w_busy_end", 32'(busy), 32'd0);

    // Read 0x21: 0x96 then 0x0F, master ACK then NACK.
    tx_data = 8'h96; tx_valid = 1'b1; base_tx = tx_pulses; base_stop = stop_pulses;
    i2c_start();
    write_byte(8'h43, ack); chk("r_addr_ack", 32'(ack), 32'd0);
    read8(b); chk("r_byte0", 32'(b), 32'h96);
    tx_data = 8'h0F;
    write_bit(1'b0);
    read8(b); chk("r_byte1", 32'(b), 32'h0F);
    write_bit(1'b1);
    tick(4); chk("r_sda_released", 32'(sda_o), 32'd1);
    i2c_stop(); tick(8);
    chk("r_tx_ready_pulses", 32'(tx_pulses - base_tx), 32'd2);
    chk("r_evt_stop", 32'(stop_pulses - base_stop), 32'd1);
    tx_valid = 1'b0;

    // Address masking and rejected addresses.
    rxq.delete(); base_stop = stop_pulses;
    i2c_start();
    write_byte(8'h44, ack); chk("m_22_ack", 32'(ack), 32'd0);
    chk("m_22_matched", 32'(matched_addr), 32'h22);
    i2c_stop(); tick(8);
    i2c_start();
    write_byte(8'h8A, ack); chk("m_45_nack", 32'(ack), 32'd1);
    chk("m_45_busy", 32'(busy), 32'd0);
    write_byte(8'h11, ack); chk("m_45_data_nack", 32'(ack), 32'd1);
    i2c_stop(); tick(8);
    i2c_start();
    write_byte(8'h00, ack); chk("m_gencall_nack", 32'(ack), 32'd1);
    i2c_stop(); tick(8);
    chk("m_stop_pulses", 32'(stop_pulses - base_stop), 32'd1);
    chk("m_no_rx", 32'(rxq.size()), 32'd0);

    // Rx overflow: consumer stalled for two bytes.
    rxq.delete(); rx_ready = 1'b0; base_err = err_pulses;
    i2c_start();
    write_byte(8'h42, ack); chk("o_addr_ack", 32'(ack), 32'd0);
    write_byte(8'hA5, ack); chk("o_ack0", 32'(ack), 32'd0);
    chk("o_held", 32'({rx_valid, rx_first, rx_data}), 32'h3A5);
`ifdef I2C_TARGET_CLK_STRETCH_EN
    fork
      write_byte(8'h3C, ack);
      begin
        wait_stretch("o_stretch");
        chk("o_stretch_data", 32'(rx_data), 32'hA5);
        rx_ready = 1'b1;
      end
    join
    chk("o_ack1", 32'(ack), 32'd0);
    i2c_stop(); tick(8);
    chk("o_rx_count", 32'(rxq.size()), 32'd2);
    chk("o_rx0", get_rx(0), 32'h1A5);
    chk("o_rx1", get_rx(1), 32'h03C);
    chk("o_no_err", 32'(err_pulses - base_err), 32'd0);
`else
    write_byte(8'h3C, ack); chk("o_nack1", 32'(ack), 32'd1);
    chk("o_evt_err", 32'(err_pulses - base_err), 32'd1);
    chk("o_kept", 32'(rx_data), 32'hA5);
    i2c_stop();
    rx_ready = 1'b1; tick(4);
    chk("o_rx_count", 32'(rxq.size()), 32'd1);
    chk("o_rx0", get_rx(0), 32'h1A5);
    chk("o_drained", 32'(rx_valid), 32'd0);
`endif

    // Tx underflow: nothing offered at read start.
    tx_valid = 1'b0; base_tx = tx_pulses; base_err = err_pulses;
    i2c_start();
    write_byte(8'h43, ack); chk("u_addr_ack", 32'(ack), 32'd0);
`ifdef I2C_TARGET_CLK_STRETCH_EN
    fork
      read8(b);
      begin
        wait_stretch("u_stretch");
        tx_data = 8'h5A;
        tx_valid = 1'b1;
      end
    join
    chk("u_byte", 32'(b), 32'h5A);
    chk("u_tx_ready", 32'(tx_pulses - base_tx), 32'd1);
    chk("u_no_err", 32'(err_pulses - base_err), 32'd0);
`else
    read8(b);
    chk("u_byte_ff", 32'(b), 32'hFF);
    chk("u_evt_err", 32'(err_pulses - base_err), 32'd1);
    chk("u_no_tx_ready", 32'(tx_pulses - base_tx), 32'd0);
`endif
    write_bit(1'b1);
    i2c_stop(); tick(8);
    tx_valid = 1'b0;

    // Repeated START mid-write, read, then a fresh write.
    rxq.delete(); rx_ready = 1'b1; tx_data = 8'h3C; tx_valid = 1'b1;
    base_stop = stop_pulses;
    i2c_start();
    write_byte(8'h42, ack); chk("s_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h77, ack); chk("s_ack0", 32'(ack), 32'd0);
    pat = 8'hA0;
    for (int i = 7; i >= 4; i--) write_bit(pat[i]);
    i2c_start();
    write_byte(8'h43, ack); chk("s_rd_addr_ack", 32'(ack), 32'd0);
    read8(b); chk("s_rd_byte", 32'(b), 32'h3C);
    write_bit(1'b1);
    i2c_start();
    write_byte(8'h42, ack); chk("s_wr2_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h88, ack); chk("s_wr2_ack", 32'(ack), 32'd0);
    i2c_stop(); tick(8);
    chk("s_rx_count", 32'(rxq.size()), 32'd2);
    chk("s_rx0", get_rx(0), 32'h177);
    chk("s_rx1", get_rx(1), 32'h188);
    chk("s_evt_stop", 32'(stop_pulses - base_stop), 32'd1);
    tx_valid = 1'b0;

    // Reset while ACK is driven and a byte is buffered.
    rx_ready = 1'b0;
    i2c_start();
    write_byte(8'h42, ack); chk("x_addr_ack", 32'(ack), 32'd0);
    pat = 8'hA5;
    for (int i = 7; i >= 0; i--) write_bit(pat[i]);
    chk("x_ack_driven", 32'(sda_o), 32'd0);
    chk("x_buffered", 32'({rx_valid, busy}), 32'h3);
    #2;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    #1;
    chk("x_async_reset", reset_vec(), 32'h00C0_0000);
    tick(3);
    rst = 1'b0;
    tick(6);
    chk("x_after_reset", reset_vec(), 32'h00C0_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
